ds_crack_decoder: RTL and testbench

DS_CRACK_DECODER -- requirements
Module: ds_crack_decoder

---
 rtl/ds_decode_pkg.sv | 40 ++++
 rtl/ds_field_decode.sv | 93 +++++++++
 rtl/ds_crack_decoder.sv | 185 ++++++++++++++++++
 tb/tb_ds_crack_decoder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_decode_pkg.sv
// Shared constants and types for the DS-form load/store crack decoder.
// Optional feature macro: DS_STQ_CRACK_EN (cracks STQ into two micro-ops).
package ds_decode_pkg;

    // Primary opcodes of the DS-form doubleword load and store groups
    localparam logic [5:0] OPC_DS_LOAD  = 6'd58;
    localparam logic [5:0] OPC_DS_STORE = 6'd62;

    // Bit positions of the DS-form fields within a 32-bit instruction word
    localparam int OPC_LSB = 26;
    localparam int RT_LSB  = 21;
    localparam int RA_LSB  = 16;
    localparam int DS_LSB  = 2;

    // Functional-unit code for the load/store unit
    localparam logic [1:0] FU_LSU = 2'b01;

    // Micro-op codes
    typedef enum logic [2:0] {
        UOP_LD   = 3'd0,
        UOP_LDU  = 3'd1,
        UOP_LWA  = 3'd2,
        UOP_STD  = 3'd3,
        UOP_STDU = 3'd4,
        UOP_STQ  = 3'd5
    } uop_e;

    // Crack sequencer states; the second state exists only when STQ is cracked
`ifdef DS_STQ_CRACK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_CRACK2 = 1'b1
    } state_e;
`else
    typedef enum logic {
        ST_IDLE = 1'b0
    } state_e;
`endif

endpackage

// File: rtl/ds_field_decode.sv
// Combinational DS-form field extraction and classification to a micro-op.
// Optional feature macro: DS_STQ_CRACK_EN (flags even-RS STQ for cracking).
module ds_field_decode
    import ds_decode_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_WIDTH   = 5,
    parameter int DATA_WIDTH  = 64
) (
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic                   o_emit,
`ifdef DS_STQ_CRACK_EN
    output logic                   o_crack,
`endif
    output uop_e                   o_uop,
    output logic [REG_WIDTH-1:0]   o_rt,
    output logic [REG_WIDTH-1:0]   o_ra,
    output logic [DATA_WIDTH-1:0]  o_imm,
    output logic                   o_ra_zero,
    output logic                   o_writes_ra,
    output logic                   o_illegal
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rt;
    logic [4:0]  w_ra;
    logic [13:0] w_ds;
    logic [1:0]  w_xo;

    assign w_opcode = i_instr[OPC_LSB +: 6];
    assign w_rt     = i_instr[RT_LSB  +: 5];
    assign w_ra     = i_instr[RA_LSB  +: 5];
    assign w_ds     = i_instr[DS_LSB  +: 14];
    assign w_xo     = i_instr[1:0];

    assign o_rt  = REG_WIDTH'(w_rt);
    assign o_ra  = REG_WIDTH'(w_ra);
    // Byte displacement is the word-aligned DS field, sign-extended
    assign o_imm = DATA_WIDTH'($signed({w_ds, 2'b00}));

    // Classify opcode/XO into a micro-op and its legality
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        o_emit      = 1'b0;
`ifdef DS_STQ_CRACK_EN
        o_crack     = 1'b0;
`endif
        o_uop       = UOP_LD;
        o_ra_zero   = 1'b1;
        o_writes_ra = 1'b0;
        o_illegal   = 1'b0;
        if (w_opcode == OPC_DS_LOAD) begin
            o_emit = 1'b1;
            unique case (w_xo)
                2'd0: o_uop = UOP_LD;
                2'd1: begin
                    o_uop       = UOP_LDU;
                    o_ra_zero   = 1'b0;
                    o_writes_ra = 1'b1;
                    o_illegal   = (w_ra == 5'd0) || (w_ra == w_rt);
                end
                2'd2: o_uop = UOP_LWA;
                default: o_illegal = 1'b1;
            endcase
        end else if (w_opcode == OPC_DS_STORE) begin
            o_emit = 1'b1;
            unique case (w_xo)
                2'd0: o_uop = UOP_STD;
                2'd1: begin
                    o_uop       = UOP_STDU;
                    o_ra_zero   = 1'b0;
                    o_writes_ra = 1'b1;
                    o_illegal   = (w_ra == 5'd0);
                end
                2'd2: begin
                    o_uop = UOP_STQ;
`ifdef DS_STQ_CRACK_EN
                    // The register pair must start on an even register
                    o_illegal = w_rt[0];
                    o_crack   = !w_rt[0];
`else
                    o_illegal = 1'b1;
`endif
                end
                default: begin
                    o_uop     = UOP_STD;
                    o_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ds_crack_decoder.sv
// DS-form load/store decoder with valid/ready handshakes on both sides.
// Emits one micro-op per instruction, or two for a cracked STQ.
// Optional feature macro: DS_STQ_CRACK_EN (STQ cracked into RS and RS+1 halves).
module ds_crack_decoder
    import ds_decode_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_WIDTH   = 5,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [TAG_WIDTH-1:0]   tag_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [REG_WIDTH-1:0]   rt_o,
    output logic [REG_WIDTH-1:0]   ra_o,
    output logic                   ra_zero_o,
    output logic [DATA_WIDTH-1:0]  imm_o,
    output logic [2:0]             uop_o,
    output logic [1:0]             fu_code_o,
    output logic                   writes_ra_o,
    output logic                   last_uop_o,
    output logic                   illegal_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    state_e                  r_state;
    state_e                  w_next_state;
    logic                    r_valid;
    logic [REG_WIDTH-1:0]    r_rt;
    logic [REG_WIDTH-1:0]    r_ra;
    logic                    r_ra_zero;
    logic [DATA_WIDTH-1:0]   r_imm;
    uop_e                    r_uop;
    logic [1:0]              r_fu_code;
    logic                    r_writes_ra;
    logic                    r_last;
    logic                    r_illegal;
    logic [TAG_WIDTH-1:0]    r_tag;

    logic                    w_accept;
    logic                    w_take;
    logic                    w_load_first;
    logic                    w_load_second;
    logic                    w_first_last;
    logic                    w_dec_emit;
    uop_e                    w_dec_uop;
    logic [REG_WIDTH-1:0]    w_dec_rt;
    logic [REG_WIDTH-1:0]    w_dec_ra;
    logic [DATA_WIDTH-1:0]   w_dec_imm;
    logic                    w_dec_ra_zero;
    logic                    w_dec_writes_ra;
    logic                    w_dec_illegal;
`ifdef DS_STQ_CRACK_EN
    logic                    w_dec_crack;
`endif

    ds_field_decode #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .REG_WIDTH   (REG_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_field_decode (
        .i_instr     (instr_i),
        .o_emit      (w_dec_emit),
`ifdef DS_STQ_CRACK_EN
        .o_crack     (w_dec_crack),
`endif
        .o_uop       (w_dec_uop),
        .o_rt        (w_dec_rt),
        .o_ra        (w_dec_ra),
        .o_imm       (w_dec_imm),
        .o_ra_zero   (w_dec_ra_zero),
        .o_writes_ra (w_dec_writes_ra),
        .o_illegal   (w_dec_illegal)
    );

    // Input may load in the same cycle the held micro-op is consumed
    assign ready_o  = (r_state == ST_IDLE) && (!r_valid || ready_i);
    assign w_accept = valid_i && ready_o;
    assign w_take   = r_valid && ready_i;

`ifdef DS_STQ_CRACK_EN
    assign w_first_last = !w_dec_crack;
`else
    assign w_first_last = 1'b1;
`endif

    // Crack sequencer state register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output-register load decisions
    always_comb begin
        w_next_state  = r_state;
        w_load_first  = 1'b0;
        w_load_second = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && w_dec_emit) begin
                    w_load_first = 1'b1;
`ifdef DS_STQ_CRACK_EN
                    if (w_dec_crack) begin
                        w_next_state = ST_CRACK2;
                    end
`endif
                end
            end
`ifdef DS_STQ_CRACK_EN
            ST_CRACK2: begin
                if (w_take) begin
                    w_load_second = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
`endif
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output valid: set on any micro-op load, cleared when consumed
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_valid <= 1'b0;
        end else if (w_load_first || w_load_second) begin
            r_valid <= 1'b1;
        end else if (w_take) begin
            r_valid <= 1'b0;
        end
    end

    // Micro-op payload: load from decoder, or derive the second STQ half in place
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rt        <= '0;
            r_ra        <= '0;
            r_ra_zero   <= 1'b0;
            r_imm       <= '0;
            r_uop       <= UOP_LD;
            r_fu_code   <= 2'b00;
            r_writes_ra <= 1'b0;
            r_last      <= 1'b0;
            r_illegal   <= 1'b0;
            r_tag       <= '0;
        end else if (w_load_first) begin
            r_rt        <= w_dec_rt;
            r_ra        <= w_dec_ra;
            r_ra_zero   <= w_dec_ra_zero;
            r_imm       <= w_dec_imm;
            r_uop       <= w_dec_uop;
            r_fu_code   <= FU_LSU;
            r_writes_ra <= w_dec_writes_ra;
            r_last      <= w_first_last;
            r_illegal   <= w_dec_illegal;
            r_tag       <= tag_i;
        end else if (w_load_second) begin
            r_rt   <= r_rt + REG_WIDTH'(1);
            r_imm  <= r_imm + DATA_WIDTH'(8);
            r_last <= 1'b1;
        end
    end

    assign valid_o     = r_valid;
    assign rt_o        = r_rt;
    assign ra_o        = r_ra;
    assign ra_zero_o   = r_ra_zero;
    assign imm_o       = r_imm;
    assign uop_o       = r_uop;
    assign fu_code_o   = r_fu_code;
    assign writes_ra_o = r_writes_ra;
    assign last_uop_o  = r_last;
    assign illegal_o   = r_illegal;
    assign tag_o       = r_tag;

endmodule

// File: tb/tb_ds_crack_decoder.sv
// Scoreboard bench for ds_crack_decoder: expectations are queued when an
// instruction is accepted and compared as micro-ops leave the output port.
module tb_ds_crack_decoder;

    localparam logic [2:0] U_LD   = 3'd0;
    localparam logic [2:0] U_LDU  = 3'd1;
    localparam logic [2:0] U_LWA  = 3'd2;
    localparam logic [2:0] U_STD  = 3'd3;
    localparam logic [2:0] U_STDU = 3'd4;
    localparam logic [2:0] U_STQ  = 3'd5;

    typedef struct {
        logic [4:0]  rt;
        logic [4:0]  ra;
        logic [63:0] imm;
        logic [2:0]  uop;
        logic        chk_uop;
        logic        ra_zero;
        logic        writes_ra;
        logic        last;
        logic        illegal;
        logic [7:0]  tag;
    } exp_t;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] instr_i;
    logic [7:0]  tag_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rt_o;
    logic [4:0]  ra_o;
    logic        ra_zero_o;
    logic [63:0] imm_o;
    logic [2:0]  uop_o;
    logic [1:0]  fu_code_o;
    logic        writes_ra_o;
    logic        last_uop_o;
    logic        illegal_o;
    logic [7:0]  tag_o;
    logic        valid_o;
    logic        ready_i;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rand_ready  = 1'b0;
    logic ready_force = 1'b1;

    ds_crack_decoder dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .instr_i     (instr_i),
        .tag_i       (tag_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .rt_o        (rt_o),
        .ra_o        (ra_o),
        .ra_zero_o   (ra_zero_o),
        .imm_o       (imm_o),
        .uop_o       (uop_o),
        .fu_code_o   (fu_code_o),
        .writes_ra_o (writes_ra_o),
        .last_uop_o  (last_uop_o),
        .illegal_o   (illegal_o),
        .tag_o       (tag_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    always #5 clock_i = ~clock_i;

    // Downstream ready: random or forced, changed just after each rising edge
    always @(posedge clock_i) begin
        #1;
        ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Reference model: expected micro-ops for one accepted instruction
    task automatic push_expected(input logic [31:0] instr, input logic [7:0] tag);
        exp_t e;
        exp_t e2;
        logic [5:0] opc;
        logic [1:0] xo;
        opc         = instr[31:26];
        xo          = instr[1:0];
        e.rt        = instr[25:21];
        e.ra        = instr[20:16];
        e.imm       = {{48{instr[15]}}, instr[15:2], 2'b00};
        e.uop       = U_LD;
        e.chk_uop   = 1'b1;
        e.ra_zero   = 1'b1;
        e.writes_ra = 1'b0;
        e.last      = 1'b1;
        e.illegal   = 1'b0;
        e.tag       = tag;
        if (opc == 6'd58) begin
            case (xo)
                2'd0: e.uop = U_LD;
                2'd1: begin
                    e.uop = U_LDU; e.ra_zero = 1'b0; e.writes_ra = 1'b1;
                    e.illegal = (e.ra == 5'd0) || (e.ra == e.rt);
                end
                2'd2: e.uop = U_LWA;
                default: begin e.illegal = 1'b1; e.chk_uop = 1'b0; end
            endcase
            sb.push_back(e);
        end else if (opc == 6'd62) begin
            case (xo)
                2'd0: e.uop = U_STD;
                2'd1: begin
                    e.uop = U_STDU; e.ra_zero = 1'b0; e.writes_ra = 1'b1;
                    e.illegal = (e.ra == 5'd0);
                end
                2'd2: begin
                    e.uop = U_STQ;
`ifdef DS_STQ_CRACK_EN
                    if (e.rt[0]) begin
                        e.illegal = 1'b1;
                    end else begin
                        e.last = 1'b0;
                        e2 = e;
                        e2.rt   = e.rt + 5'd1;
                        e2.imm  = e.imm + 64'd8;
                        e2.last = 1'b1;
                        sb.push_back(e);
                        e = e2;
                    end
`else
                    e.illegal = 1'b1;
`endif
                end
                default: begin e.illegal = 1'b1; e.chk_uop = 1'b0; end
            endcase
            sb.push_back(e);
        end
    endtask

    // Output monitor: a micro-op transfers at the next edge when valid_o and ready_i are high
    always @(negedge clock_i) begin
        exp_t e;
        if (reset_n_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_uop", {59'd0, rt_o}, 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("uop_rt", {59'd0, rt_o}, {59'd0, e.rt});
                check("uop_ra", {59'd0, ra_o}, {59'd0, e.ra});
                check("uop_imm", imm_o, e.imm);
                if (e.chk_uop) check("uop_code", {61'd0, uop_o}, {61'd0, e.uop});
                check("uop_fu", {62'd0, fu_code_o}, 64'd1);
                check("uop_ra_zero", {63'd0, ra_zero_o}, {63'd0, e.ra_zero});
                check("uop_writes_ra", {63'd0, writes_ra_o}, {63'd0, e.writes_ra});
                check("uop_last", {63'd0, last_uop_o}, {63'd0, e.last});
                check("uop_illegal", {63'd0, illegal_o}, {63'd0, e.illegal});
                check("uop_tag", {56'd0, tag_o}, {56'd0, e.tag});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock_i);
        #2;
    endtask

    // Present one instruction and wait (bounded) for acceptance; valid_i stays high on return
    task automatic send(input logic [31:0] instr, input logic [7:0] tag);
        bit ok;
        ok = 1'b0;
        instr_i = instr;
        tag_i   = tag;
        valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock_i);
            if (ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            push_expected(instr, tag);
            @(posedge clock_i);
            #2;
        end else begin
            check("accept_timeout", 64'd0, 64'd1);
            valid_i = 1'b0;
        end
    endtask

    task automatic idle();
        valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        reset_n_i = 1'b0;
        valid_i   = 1'b0;
        instr_i   = '0;
        tag_i     = '0;

        // Reset state
        repeat (2) @(negedge clock_i);
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_rt", {59'd0, rt_o}, 64'd0);
        check("rst_ra", {59'd0, ra_o}, 64'd0);
        check("rst_imm", imm_o, 64'd0);
        check("rst_uop", {61'd0, uop_o}, 64'd0);
        check("rst_fu", {62'd0, fu_code_o}, 64'd0);
        check("rst_tag", {56'd0, tag_o}, 64'd0);
        check("rst_flags", {60'd0, ra_zero_o, writes_ra_o, last_uop_o, illegal_o}, 64'd0);
        @(posedge clock_i);
        #2;
        reset_n_i = 1'b1;
        step(1);

        // ld r3,16(r1): one-cycle latency and the plain-load fields
        send(32'hE861_0010, 8'h11);
        idle();
        @(negedge clock_i);
        check("ld_latency_valid", {63'd0, valid_o}, 64'd1);
        check("ld_rt", {59'd0, rt_o}, 64'd3);
        check("ld_imm", imm_o, 64'h10);
        check("ld_uop", {61'd0, uop_o}, {61'd0, U_LD});
        step(2);

        // std r5,-8(r2), ldu r3,0(r3), lwa, stdu ra=0, illegal XO=3, odd-RS stq
        send(32'hF8A2_FFF8, 8'h22);
        idle();
        @(negedge clock_i);
        check("std_imm_neg", imm_o, 64'hFFFF_FFFF_FFFF_FFF8);
        step(1);
        send(32'hE863_0001, 8'h33);
        idle();
        @(negedge clock_i);
        check("ldu_illegal", {62'd0, writes_ra_o, illegal_o}, 64'd3);
        step(1);
        send(32'hE881_0006, 8'h34);
        send(32'hF860_0009, 8'h35);
        send(32'hE822_0003, 8'h36);
        send(32'hF8A1_0022, 8'h37);
        idle();
        step(3);

        // Unknown opcode is accepted and dropped
        send(32'h3860_0005, 8'h38);
        idle();
        step(3);
        check("drop_no_uop", sb.size(), 64'd0);

        // Back-pressure: output frozen for 3 cycles with a second instruction waiting
        ready_force = 1'b0;
        step(1);
        send(32'hE861_0010, 8'h44);
        fork
            send(32'hF8A2_FFF8, 8'h55);
            begin
                repeat (3) begin
                    @(negedge clock_i);
                    check("hold_ready_o", {63'd0, ready_o}, 64'd0);
                    check("hold_valid", {63'd0, valid_o}, 64'd1);
                    check("hold_rt", {59'd0, rt_o}, 64'd3);
                    check("hold_tag", {56'd0, tag_o}, 64'h44);
                end
                ready_force = 1'b1;
                @(negedge clock_i);
                check("release_ready_o", {63'd0, ready_o}, 64'd1);
                @(negedge clock_i);
                check("b2b_valid", {63'd0, valid_o}, 64'd1);
                check("b2b_tag", {56'd0, tag_o}, 64'h55);
            end
        join
        idle();
        step(2);

        // stq r4,32(r1)
        send(32'hF881_0022, 8'h66);
        idle();
        @(negedge clock_i);
`ifdef DS_STQ_CRACK_EN
        check("stq1_last", {63'd0, last_uop_o}, 64'd0);
        check("stq1_ready_o", {63'd0, ready_o}, 64'd0);
        check("stq1_rt", {59'd0, rt_o}, 64'd4);
        @(negedge clock_i);
        check("stq2_rt", {59'd0, rt_o}, 64'd5);
        check("stq2_imm", imm_o, 64'h28);
        check("stq2_last", {63'd0, last_uop_o}, 64'd1);
`else
        check("stq_illegal", {62'd0, last_uop_o, illegal_o}, 64'd3);
`endif
        step(2);

        // Reset asserted while a micro-op (or the STQ crack) is pending
        ready_force = 1'b0;
        step(1);
`ifdef DS_STQ_CRACK_EN
        send(32'hF881_0022, 8'h77);
`else
        send(32'hE861_0010, 8'h77);
`endif
        idle();
        @(negedge clock_i);
        check("pre_rst_valid", {63'd0, valid_o}, 64'd1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, valid_o}, 64'd0);
        check("mid_rst_rt", {59'd0, rt_o}, 64'd0);
        check("mid_rst_imm", imm_o, 64'd0);
        check("mid_rst_flags", {60'd0, ra_zero_o, writes_ra_o, last_uop_o, illegal_o}, 64'd0);
        sb.delete();
        ready_force = 1'b1;
        @(negedge clock_i);
        #2;
        reset_n_i = 1'b1;
        step(6);
        check("post_rst_quiet", {63'd0, valid_o}, 64'd0);

        // Random mix with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            case ($urandom_range(0, 2))
                0: w[31:26] = 6'd58;
                1: w[31:26] = 6'd62;
                default: if (w[31:26] == 6'd58 || w[31:26] == 6'd62) w[31:26] = 6'd14;
            endcase
            send(w, 8'(i + 128));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                step(1);
            end
        end
        idle();
        rand_ready = 1'b0;
        ready_force = 1'b1;
        step(10);
        check("drain_empty", sb.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
